// File: rtl/watchdog_multi.sv
// -----------------------------------------------------------------------------
// watchdog_multi
//
// A bank of NUM_CH independent watchdog channels on one clock. Each channel
// counts idle cycles while enabled. A heartbeat (kick) restarts the count. If
// the count reaches TIMEOUT-1 and no kick arrives, the channel trips. A
// tripped channel stays latched until clear_trigger. Any new trip also starts
// a force_reset pulse that lasts RST_PULSE cycles.
//
// Ports
//   clk            in   1       single clock, rising edge
//   rstn           in   1       asynchronous active-low reset
//   enable         in   NUM_CH  per-channel enable (level)
//   heartbeat      in   NUM_CH  per-channel kick; every high cycle is one kick
//   clear_trigger  in   1       returns every tripped channel to OFF
//   warning        out  NUM_CH  idle count >= WARN (held high while tripped)
//   triggered      out  NUM_CH  sticky trip flag
//   force_reset    out  1       system reset request pulse
//   fault_ch       out  4       lowest channel that tripped in the latest trip cycle
//
// Optional feature
//   WATCHDOG_WINDOW_EN  when defined, a kick in RUN while the count is below
//                       WIN_MIN is "early" and trips the channel. The first
//                       kick after entering RUN is exempt from this check.
// -----------------------------------------------------------------------------
module watchdog_multi #(
  parameter int     NUM_CH    = 4,
  parameter int     CNT_W     = 32,
  parameter longint TIMEOUT   = 1000,
  parameter longint WARN      = 750,
  parameter longint WIN_MIN   = 100,
  parameter int     RST_PULSE = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic              clear_trigger,
  output logic [NUM_CH-1:0] warning,
  output logic [NUM_CH-1:0] triggered,
  output logic              force_reset,
  output logic [3:0]        fault_ch
);

`ifdef WATCHDOG_WINDOW_EN
  localparam bit WIN_ON = 1'b1;
`else
  localparam bit WIN_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_WARN  = CNT_W'(WARN);
  localparam logic [CNT_W-1:0] CNT_WIN   = CNT_W'(WIN_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       PULSE_LEN = 8'(RST_PULSE);

  typedef enum logic [1:0] {CH_OFF, CH_RUN, CH_TRIP} ch_state_e;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] kicked_q, kicked_d;
  logic [NUM_CH-1:0] warn_d, trig_d;
  logic [NUM_CH-1:0] early, trip_now;
  logic [7:0]        pulse_q, pulse_d;
  logic              force_d;
  logic [3:0]        fault_d;

  // Per-channel next state.
  // NOTE: every variable gets its default at the top of the block, so no path
  // leaves one unassigned and no latch can be inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      kicked_d[i] = kicked_q[i];
      warn_d[i]   = warning[i];
      trip_now[i] = 1'b0;
      // Early kick: only with the window enabled and only after the first kick.
      early[i]    = WIN_ON && kicked_q[i] && (cnt_q[i] < CNT_WIN);

      case (state_q[i])
        CH_OFF: begin
          cnt_d[i]  = '0;
          warn_d[i] = 1'b0;
          if (enable[i]) begin
            state_d[i]  = CH_RUN;
            kicked_d[i] = 1'b0;
          end
        end
        CH_RUN: begin
          if (!enable[i]) begin
            state_d[i] = CH_OFF;
            cnt_d[i]   = '0;
            warn_d[i]  = 1'b0;
          end else if (heartbeat[i] && !early[i]) begin
            // A legal kick beats a timeout in the same cycle.
            cnt_d[i]    = '0;
            warn_d[i]   = 1'b0;
            kicked_d[i] = 1'b1;
          end else if (heartbeat[i] || (cnt_q[i] == CNT_LAST)) begin
            trip_now[i] = 1'b1;
          end else begin
            // Only reached below CNT_LAST, so the count saturates there.
            cnt_d[i]  = cnt_q[i] + CNT_ONE;
            warn_d[i] = (cnt_d[i] >= CNT_WARN);
          end
          if (trip_now[i]) begin
            state_d[i] = CH_TRIP;
            warn_d[i]  = 1'b1;
          end
        end
        CH_TRIP: begin
          // Only channels already tripped are cleared; a channel tripping this
          // very cycle is still in RUN here, so its trip wins over the clear.
          if (clear_trigger) begin
            state_d[i] = CH_OFF;
            cnt_d[i]   = '0;
            warn_d[i]  = 1'b0;
          end
        end
        default: begin
          state_d[i] = CH_OFF;
          cnt_d[i]   = '0;
          warn_d[i]  = 1'b0;
        end
      endcase

      trig_d[i] = (state_d[i] == CH_TRIP);
    end
  end

  // Shared trip bookkeeping: pulse length counter and fault index.
  always_comb begin
    fault_d = fault_ch;
    // Descending scan so the lowest tripping channel is written last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (trip_now[i]) fault_d = 4'(i);
    end
    if (|trip_now) begin
      pulse_d = PULSE_LEN;
    end else if (pulse_q != 8'd0) begin
      pulse_d = pulse_q - 8'd1;
    end else begin
      pulse_d = 8'd0;
    end
    // pulse_q counts the high cycles still owed including the current one,
    // so the output stays up while more than one remains.
    force_d = (|trip_now) || (pulse_q > 8'd1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the per-channel arrays are a handful of flops rather than a RAM,
  // so they are reset along with everything else.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_OFF;
        cnt_q[i]   <= '0;
      end
      kicked_q    <= '0;
      warning     <= '0;
      triggered   <= '0;
      pulse_q     <= 8'd0;
      force_reset <= 1'b0;
      fault_ch    <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      kicked_q    <= kicked_d;
      warning     <= warn_d;
      triggered   <= trig_d;
      pulse_q     <= pulse_d;
      force_reset <= force_d;
      fault_ch    <= fault_d;
    end
  end

endmodule

// File: tb/tb_watchdog_multi.sv
// -----------------------------------------------------------------------------
// tb_watchdog_multi
//
// Bench for watchdog_multi with NUM_CH=2, TIMEOUT=16, WARN=12, WIN_MIN=4,
// RST_PULSE=4. It runs a table of {inputs, expected outputs} segments, a set
// of hand-written multi-cycle sequences, and a randomized run that is checked
// against an idle-count reference model. Honours WATCHDOG_WINDOW_EN.
// -----------------------------------------------------------------------------
module tb_watchdog_multi;

  localparam int     NUM_CH    = 2;
  localparam int     CNT_W     = 8;
  localparam longint TIMEOUT   = 16;
  localparam longint WARN      = 12;
  localparam longint WIN_MIN   = 4;
  localparam int     RST_PULSE = 4;

`ifdef WATCHDOG_WINDOW_EN
  localparam bit WINDOW = 1'b1;
`else
  localparam bit WINDOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] enable = '0;
  logic [1:0] heartbeat = '0;
  logic       clear_trigger = 1'b0;
  logic [1:0] warning;
  logic [1:0] triggered;
  logic       force_reset;
  logic [3:0] fault_ch;

  int checks = 0;
  int failures = 0;

  watchdog_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .WARN     (WARN),
    .WIN_MIN  (WIN_MIN),
    .RST_PULSE(RST_PULSE)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .heartbeat    (heartbeat),
    .clear_trigger(clear_trigger),
    .warning      (warning),
    .triggered    (triggered),
    .force_reset  (force_reset),
    .fault_ch     (fault_ch)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (warn,trig,force,fault)", name, act[8:0], exp[8:0]);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, warning, triggered, force_reset, fault_ch};
  endfunction

  task automatic check_all(input string name, input logic [1:0] w, input logic [1:0] t,
                           input logic f, input logic [3:0] fa);
    check(name, outs(), {23'd0, w, t, f, fa});
  endtask

  task automatic drive(input logic [1:0] en, input logic [1:0] hb, input logic clr);
    enable = en;
    heartbeat = hb;
    clear_trigger = clr;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 1'b0);
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  // ------------------------------------------------------- reference model
  // A channel is described by whether it is enabled/running, its idle count,
  // whether it is latched tripped and whether it has been kicked since it
  // started. Outputs are derived from those facts.
  int m_idle [NUM_CH];
  bit m_on   [NUM_CH];
  bit m_trip [NUM_CH];
  bit m_kick [NUM_CH];
  int m_left;
  int m_fault;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_idle[c] = 0;
      m_on[c]   = 1'b0;
      m_trip[c] = 1'b0;
      m_kick[c] = 1'b0;
    end
    m_left  = 0;
    m_fault = 0;
  endtask

  task automatic model_step(input logic [1:0] en, input logic [1:0] hb, input logic clr);
    int lowest;
    lowest = -1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_trip[c]) begin
        if (clr) begin
          m_trip[c] = 1'b0;
          m_idle[c] = 0;
        end
      end else if (!m_on[c]) begin
        m_idle[c] = 0;
        if (en[c]) begin
          m_on[c]   = 1'b1;
          m_kick[c] = 1'b0;
        end
      end else if (!en[c]) begin
        m_on[c]   = 1'b0;
        m_idle[c] = 0;
      end else if (hb[c] && !(WINDOW && m_kick[c] && m_idle[c] < WIN_MIN)) begin
        m_idle[c] = 0;
        m_kick[c] = 1'b1;
      end else if (hb[c] || m_idle[c] == TIMEOUT - 1) begin
        m_trip[c] = 1'b1;
        m_on[c]   = 1'b0;
        if (lowest < 0) lowest = c;
      end else begin
        m_idle[c]++;
      end
    end
    if (lowest >= 0) begin
      m_left  = RST_PULSE;
      m_fault = lowest;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  function automatic logic [31:0] model_outs();
    logic [1:0] w, t;
    for (int c = 0; c < NUM_CH; c++) begin
      t[c] = m_trip[c];
      w[c] = m_trip[c] || (m_on[c] && m_idle[c] >= WARN);
    end
    return {23'd0, w, t, (m_left > 0), 4'(m_fault)};
  endfunction

  // ------------------------------------------------------------ vector table
  typedef struct {
    int         n;      // cycles to hold these inputs
    logic [1:0] en;
    logic [1:0] hb;
    logic       clr;
    logic [1:0] warn;   // expected after the last of those cycles
    logic [1:0] trig;
    logic       frc;
    logic [3:0] fault;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic [1:0] en_r, hb_r;
    logic       clr_r;

    // Single channel, no kicks: warn at 13, trip at 17, pulse 17..20.
    vecs[0]  = '{12, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0};
    vecs[1]  = '{ 1, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 4'd0};
    vecs[2]  = '{ 3, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 4'd0};
    vecs[3]  = '{ 1, 2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 1'b1, 4'd0};
    vecs[4]  = '{ 3, 2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 1'b1, 4'd0};
    vecs[5]  = '{ 1, 2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 4'd0};
    vecs[6]  = '{ 1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0};
    // Both channels trip together: one pulse, fault 0; clear restarts counting.
    vecs[7]  = '{16, 2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 4'd0};
    vecs[8]  = '{ 1, 2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 1'b1, 4'd0};
    vecs[9]  = '{ 3, 2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 1'b1, 4'd0};
    vecs[10] = '{ 1, 2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 1'b0, 4'd0};
    vecs[11] = '{ 1, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0};
    vecs[12] = '{12, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0};
    vecs[13] = '{ 1, 2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 4'd0};
    vecs[14] = '{ 1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0};
    // Channel 1 alone: fault index 1, held after the clear.
    vecs[15] = '{ 1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0};
    vecs[16] = '{15, 2'b10, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 4'd0};
    vecs[17] = '{ 1, 2'b10, 2'b00, 1'b0, 2'b10, 2'b10, 1'b1, 4'd1};
    vecs[18] = '{ 4, 2'b10, 2'b00, 1'b0, 2'b10, 2'b10, 1'b0, 4'd1};
    vecs[19] = '{ 1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1};

    // Reset state, checked while rstn is still low.
    drive(2'b00, 2'b00, 1'b0);
    rstn = 1'b0;
    repeat (2) tick();
    check_all("reset_state", 2'b00, 2'b00, 1'b0, 4'd0);
    rstn = 1'b1;

    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].en, vecs[k].hb, vecs[k].clr);
      repeat (vecs[k].n) tick();
      check_all($sformatf("vec%0d", k), vecs[k].warn, vecs[k].trig, vecs[k].frc, vecs[k].fault);
    end

    // Kick exactly at the last count: no trip, count restarts from 0.
    do_reset();
    drive(2'b01, 2'b00, 1'b0);
    repeat (16) tick();
    check_all("kick_last_pre", 2'b01, 2'b00, 1'b0, 4'd0);
    drive(2'b01, 2'b01, 1'b0);
    tick();
    check_all("kick_last_edge", 2'b00, 2'b00, 1'b0, 4'd0);
    drive(2'b01, 2'b00, 1'b0);
    repeat (11) tick();
    check_all("kick_last_cnt11", 2'b00, 2'b00, 1'b0, 4'd0);
    tick();
    check_all("kick_last_warn", 2'b01, 2'b00, 1'b0, 4'd0);
    repeat (3) tick();
    check_all("kick_last_cnt15", 2'b01, 2'b00, 1'b0, 4'd0);
    tick();
    check_all("kick_last_trip", 2'b01, 2'b01, 1'b1, 4'd0);

    // Channel 1 kicked every 10 cycles for 100 cycles: never warns or trips.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      drive(2'b10, (c % 10 == 9) ? 2'b10 : 2'b00, 1'b0);
      tick();
      check("periodic_kick", {29'd0, warning[1], triggered[1], force_reset}, 32'd0);
    end

    // Kick at count 5 (first kick, exempt), then at count 2.
    do_reset();
    drive(2'b01, 2'b00, 1'b0);
    repeat (6) tick();
    drive(2'b01, 2'b01, 1'b0);
    tick();
    check_all("window_first_kick", 2'b00, 2'b00, 1'b0, 4'd0);
    drive(2'b01, 2'b00, 1'b0);
    repeat (2) tick();
    drive(2'b01, 2'b01, 1'b0);
    tick();
    if (WINDOW) check_all("window_early_kick", 2'b01, 2'b01, 1'b1, 4'd0);
    else        check_all("window_early_kick", 2'b00, 2'b00, 1'b0, 4'd0);

    // Trip and clear in the same cycle; a second trip restarts the pulse.
    do_reset();
    drive(2'b10, 2'b00, 1'b0);
    repeat (3) tick();
    drive(2'b11, 2'b00, 1'b0);
    repeat (14) tick();
    check_all("ch1_trip", 2'b11, 2'b10, 1'b1, 4'd1);
    repeat (2) tick();
    check_all("ch0_last", 2'b11, 2'b10, 1'b1, 4'd1);
    drive(2'b11, 2'b00, 1'b1);
    tick();
    check_all("trip_beats_clear", 2'b01, 2'b01, 1'b1, 4'd0);
    drive(2'b11, 2'b00, 1'b0);
    repeat (3) tick();
    check("pulse_restarted", {31'd0, force_reset}, 32'd1);
    tick();
    check("pulse_restart_end", {31'd0, force_reset}, 32'd0);

    // Reset dropped in the middle of a pulse.
    do_reset();
    drive(2'b01, 2'b00, 1'b0);
    repeat (18) tick();
    check_all("mid_pulse", 2'b01, 2'b01, 1'b1, 4'd0);
    rstn = 1'b0;
    #1;
    check_all("async_reset", 2'b00, 2'b00, 1'b0, 4'd0);
    tick();
    rstn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check_all($sformatf("post_reset_%0d", c), 2'b00, 2'b00, 1'b0, 4'd0);
    end
    tick();
    check_all("post_reset_warn", 2'b01, 2'b00, 1'b0, 4'd0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    en_r = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 63) == 0) en_r[ch] = ~en_r[ch];
        if ((c / 500) % 2 == 1) hb_r[ch] = ($urandom_range(0, 7) == 0);
        else                    hb_r[ch] = ($urandom_range(0, 19) == 0);
      end
      clr_r = ($urandom_range(0, 39) == 0);
      drive(en_r, hb_r, clr_r);
      tick();
      model_step(en_r, hb_r, clr_r);
      check($sformatf("random_c%0d", c), outs(), model_outs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watchdog_multi.md
WATCHDOG_MULTI -- requirements
Module: watchdog_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent watchdog channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter width in bits.
REQ-003 Parameter TIMEOUT, default 1000, idle cycles until a channel trips (2..2^CNT_W-1).
REQ-004 Parameter WARN, default 750, idle cycles until warning asserts (1..TIMEOUT-1).
REQ-005 Parameter WIN_MIN, default 100, minimum legal heartbeat spacing in window mode (0..WARN-1).
REQ-006 Parameter RST_PULSE, default 8, force_reset pulse length in cycles (1..255).
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rstn  in  1  reset, asynchronous assert, active-low.
REQ-009 enable  in  NUM_CH  per-channel enable, level.
REQ-010 heartbeat  in  NUM_CH  per-channel kick, one-cycle or level; each high cycle is one kick.
REQ-011 clear_trigger  in  1  clears all tripped channels.
REQ-012 warning  out  NUM_CH  registered, channel idle count >= WARN.
REQ-013 triggered  out  NUM_CH  registered, sticky trip flag per channel.
REQ-014 force_reset  out  1  registered system reset request pulse.
REQ-015 fault_ch  out  4  index of lowest-numbered channel that tripped in the most recent trip cycle.

Function
REQ-016 Each channel has states OFF, RUN, TRIP; counter cnt[CNT_W-1:0].
REQ-017 OFF: enable=0 forces OFF from RUN, cnt=0, warning=0; triggered retained in TRIP.
REQ-018 OFF -> RUN when enable=1; cnt starts at 0 that cycle.
REQ-019 RUN: heartbeat=1 sets cnt=0 next cycle; else cnt increments by 1.
REQ-020 warning registered high the cycle after cnt reaches WARN; cleared the cycle after a kick.
REQ-021 RUN -> TRIP when cnt == TIMEOUT-1 and no heartbeat that cycle; triggered=1 next cycle.
REQ-022 Heartbeat in the same cycle as cnt == TIMEOUT-1 wins: no trip, cnt=0.
REQ-023 TRIP: cnt frozen, heartbeat ignored, warning held 1, triggered held 1.
REQ-024 TRIP -> OFF on clear_trigger=1 (all channels), triggered=0, warning=0, cnt=0; re-enters RUN next cycle if enable=1.
REQ-025 Trip condition and clear_trigger in same cycle on same channel: trip wins, triggered=1.
REQ-026 force_reset goes high the cycle after any channel enters TRIP, stays high exactly RST_PULSE cycles; a new trip during the pulse restarts the pulse count.
REQ-027 fault_ch updates only on cycles where >=1 channel enters TRIP; holds otherwise; reset value 0.
REQ-028 Counter arithmetic never wraps; cnt saturates at TIMEOUT-1.

Reset
REQ-029 rstn=0 asynchronously forces all channels OFF, cnt=0, warning=0, triggered=0, force_reset=0, fault_ch=0, pulse counter=0.
REQ-030 Reset asserted mid-pulse terminates force_reset immediately; no pulse resumes after release.
REQ-031 First counting cycle is the first rising edge with rstn=1 and enable=1.

Configuration
REQ-032 Macro WATCHDOG_WINDOW_EN defined: heartbeat in RUN while cnt < WIN_MIN is an early kick and trips the channel (RUN -> TRIP, same timing as REQ-021).
REQ-033 WATCHDOG_WINDOW_EN undefined: early kicks are legal and reset cnt; WIN_MIN unused.
REQ-034 First kick after entering RUN is exempt from the window check.

Verification (NUM_CH=2, TIMEOUT=16, WARN=12, WIN_MIN=4, RST_PULSE=4)
REQ-035 Enable ch0, no kicks -> warning[0] high at cycle 13, triggered[0] and force_reset high at cycle 17, force_reset low at cycle 21, fault_ch=0.
REQ-036 Kick ch1 every 10 cycles for 100 cycles -> warning[1], triggered[1], force_reset never assert.
REQ-037 Kick ch0 exactly when cnt=15 -> no trip, cnt=0, warning drops next cycle.
REQ-038 Both channels trip same cycle -> triggered=2'b11, fault_ch=0, single 4-cycle pulse; clear_trigger -> triggered=0, counting restarts.
REQ-039 With WATCHDOG_WINDOW_EN: kick ch0 at cnt=5, then at cnt=2 -> trip; without macro -> no trip.
REQ-040 Drop rstn during force_reset pulse -> all outputs 0 immediately; release -> counting from 0, no residual pulse.
